mips_muldiv: RTL

Iterative unsigned multiply/divide unit that executes the MULTU and DIVU operations the ALU does not compute; the ALU drives zero on those opcodes. It owns the architectural HI/LO registers. Each operation runs a fixed 32-step radix-2 algorithm under a start/busy/done handshake, and the pipeline stalls on `busy`. It sits beside the ALU in EX; MFHI/MFLO read `hi`/`lo` directly, and MTHI/MTLO write through dedicated enables.

---
 rtl/mips_muldiv_if.sv | 26 ++
 rtl/mips_muldiv.sv | 107 ++++++++++
 2 files changed

// File: rtl/mips_muldiv_if.sv
// Start/busy/done and HI/LO access bundle for the iterative MULTU/DIVU unit.
// Master is the EX-stage issue logic; slave is the multiply/divide unit.
interface mips_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, X, Y, hi_we, lo_we, wdata,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, X, Y, hi_we, lo_we, wdata,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative unsigned MULTU (shift-add) / DIVU (restoring) unit owning HI/LO.
// Fixed 32-step radix-2 iteration, one step per clock.
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mips_muldiv_if.slave  bus,
  output logic [1:0]    dbg_state
);
  // Handshake: start is accepted only on an edge where busy is low (IDLE);
  // busy stays high from the cycle after acceptance through the done cycle,
  // done pulses for exactly one cycle with the new hi/lo, and start while busy
  // is dropped, never queued.
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

  state_t           state, state_nx;
  logic [5:0]       cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             dz_r;

  logic             launch, stepping, last_step;
  logic [WIDTH:0]   mul_sum, div_sh, step_acc;
  logic [WIDTH-1:0] step_q;
  logic             div_ge;

  assign launch    = (state == S_IDLE) && bus.start;
  assign stepping  = (state == S_MUL) || (state == S_DIV);
  assign last_step = (cnt == LAST_STEP);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = bus.op ? S_DIV : S_MUL;
      S_MUL,
      S_DIV:   if (last_step) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy  = (state != S_IDLE);
    bus.done  = (state == S_DONE) && !rst;
    dbg_state = state;
  end

  // One iteration of either algorithm; the 33rd acc bit holds the MUL carry
  // or the DIV partial remainder's extra bit.
  always_comb begin
    mul_sum  = {1'b0, acc[WIDTH-1:0]} + (q[0] ? {1'b0, m} : '0);
    div_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, m});
    step_acc = {1'b0, mul_sum[WIDTH:1]};
    step_q   = {mul_sum[0], q[WIDTH-1:1]};
    if (state == S_DIV) begin
      step_acc = div_ge ? (div_sh - {1'b0, m}) : div_sh;
      step_q   = {q[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      acc  <= '0;
      q    <= '0;
      m    <= '0;
      dz_r <= 1'b0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      if (launch) begin
        cnt  <= '0;
        acc  <= '0;
        q    <= bus.X;
        m    <= bus.Y;
        dz_r <= bus.op && (bus.Y == '0);
      end else if (stepping) begin
        acc <= step_acc;
        q   <= step_q;
        cnt <= cnt + 6'd1;
      end
      // The last step's result lands in HI/LO on the edge that enters DONE.
      if (stepping && last_step) begin
        hi_r <= step_acc[WIDTH-1:0];
        lo_r <= step_q;
      end else if (state == S_IDLE) begin
        if (bus.hi_we) hi_r <= bus.wdata;
        if (bus.lo_we) lo_r <= bus.wdata;
      end
    end
  end

  assign bus.hi = hi_r;
  assign bus.lo = lo_r;
  assign bus.dz = dz_r;
endmodule
